// File: rtl/branch_pkg.sv
// Shared types for the branch history controller: FSM states, memory port width
// and the tracking-queue entry layout.
package branch_pkg;

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    localparam int unsigned MEM_ADDR_W = 6;
    localparam int unsigned MAX_IDX_W  = 5;

    // idx is held at the widest legal history index; narrower configs zero-extend.
    typedef struct packed {
        logic [MAX_IDX_W-1:0] idx;
        logic                 pred;
    } entry_t;

endpackage

// File: rtl/branch_pred_ctrl_if.sv
// Fetch, resolve and branchMem port signals of the branch predictor controller.
interface branch_pred_ctrl_if #(
    parameter int unsigned PC_W = 32
);
    import branch_pkg::*;

    logic                  fetch_valid;
    logic [PC_W-1:0]       fetch_pc;
    logic                  fetch_ready;
    logic                  pred_taken;
    logic                  res_valid;
    logic                  res_taken;
    logic                  mispredict;
    logic [MEM_ADDR_W-1:0] mem_addr;
    logic                  mem_wd;
    logic                  mem_we;
    logic                  mem_rd;

    // Controller side.
    modport slave (
        input  fetch_valid, fetch_pc, res_valid, res_taken, mem_rd,
        output fetch_ready, pred_taken, mispredict, mem_addr, mem_wd, mem_we
    );

    // Pipeline / memory side.
    modport master (
        output fetch_valid, fetch_pc, res_valid, res_taken, mem_rd,
        input  fetch_ready, pred_taken, mispredict, mem_addr, mem_wd, mem_we
    );

endinterface

// File: rtl/branch_fifo.sv
// In-order circular queue of in-flight branches; flush overrides push and pop.
module branch_fifo
    import branch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  entry_t                   din,
    output entry_t                   dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    entry_t               mem_q [DEPTH];
    logic [PTR_W-1:0]     head_q;
    logic [PTR_W-1:0]     tail_q;
    logic [PTR_W:0]       count_q;
    logic                 do_push;
    logic                 do_pop;

    assign full    = (count_q == (PTR_W + 1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem_q[head_q];
    assign count   = count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush) begin
            head_q  <= tail_q;
            count_q <= '0;
        end else begin
            if (do_push) begin
                tail_q <= tail_q + PTR_W'(1);
            end
            if (do_pop) begin
                head_q <= head_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
                2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: entries are only read while count is non-zero.
    always_ff @(posedge clk) begin
        if (!reset && !flush && do_push) begin
            mem_q[tail_q] <= din;
        end
    end

endmodule

// File: rtl/branch_pred_ctrl.sv
// Drives the 1-bit branch history memory: post-reset clear sweep, fetch lookups,
// and resolve-time compare with rewrite and queue flush on mispredict.
module branch_pred_ctrl
    import branch_pkg::*;
#(
    parameter int unsigned IDX_W = 5,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PC_W  = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    branch_pred_ctrl_if.slave      bus,
    output logic [$clog2(DEPTH):0] inflight,
    output logic                   res_err
);

    state_t             state_q;
    state_t             state_d;
    logic [IDX_W-1:0]   init_cnt_q;
    logic [IDX_W-1:0]   init_cnt_d;
    logic               res_err_q;
    logic               err_set;

    logic               q_push;
    logic               q_pop;
    logic               q_flush;
    logic               q_full;
    logic               q_empty;
    entry_t             q_head;
    entry_t             q_din;

    logic [IDX_W-1:0]   fetch_idx;
    logic               unused_pc;

    assign fetch_idx = bus.fetch_pc[IDX_W+1:2];
    assign unused_pc = ^{bus.fetch_pc[PC_W-1:IDX_W+2], bus.fetch_pc[1:0]};

    assign q_din.idx      = MAX_IDX_W'(fetch_idx);
    assign q_din.pred     = bus.mem_rd;
    assign bus.pred_taken = bus.mem_rd;
    assign res_err        = res_err_q;

    branch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (q_push),
        .pop   (q_pop),
        .flush (q_flush),
        .din   (q_din),
        .dout  (q_head),
        .count (inflight),
        .full  (q_full),
        .empty (q_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= INIT;
            init_cnt_q <= '0;
            res_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            if (err_set) begin
                res_err_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        init_cnt_d      = init_cnt_q;
        err_set         = 1'b0;
        q_push          = 1'b0;
        q_pop           = 1'b0;
        q_flush         = 1'b0;
        bus.fetch_ready = 1'b0;
        bus.mispredict  = 1'b0;
        bus.mem_we      = 1'b0;
        bus.mem_wd      = 1'b0;
        bus.mem_addr    = MEM_ADDR_W'(fetch_idx);

        case (state_q)
            INIT: begin
                bus.mem_we   = 1'b1;
                bus.mem_addr = MEM_ADDR_W'(init_cnt_q);
                if (init_cnt_q == '1) begin
                    state_d = RUN;
                end else begin
                    init_cnt_d = init_cnt_q + IDX_W'(1);
                end
            end

            RUN: begin
                if (bus.res_valid) begin
                    if (q_empty) begin
                        err_set = 1'b1;
                    end else begin
                        q_pop = 1'b1;
                        if (bus.res_taken != q_head.pred) begin
                            bus.mispredict = 1'b1;
                            bus.mem_we     = 1'b1;
                            bus.mem_wd     = bus.res_taken;
                            bus.mem_addr   = MEM_ADDR_W'(q_head.idx);
                            q_flush        = 1'b1;
                        end
                    end
                end
                // A rewrite owns the address port, so lookups stall that cycle.
                bus.fetch_ready = ~q_full & ~bus.mispredict;
                q_push          = bus.fetch_valid & bus.fetch_ready;
            end

            default: begin
                state_d = INIT;
            end
        endcase
    end

endmodule

// File: tb/tb_branch_pred_ctrl.sv
// Directed bench for branch_pred_ctrl with a behavioural branchMem model.
module tb_branch_pred_ctrl;

    logic clk;
    logic reset;
    logic [2:0] inflight;
    logic res_err;
    int checks;
    int errors;

    branch_pred_ctrl_if #(.PC_W(32)) bus ();

    branch_pred_ctrl #(
        .IDX_W (5),
        .DEPTH (4),
        .PC_W  (32)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .inflight (inflight),
        .res_err  (res_err)
    );

    // branchMem: no reset, powers up with stale ones so the clear sweep matters.
    logic mem_q [64] = '{default: 1'b1};
    assign bus.mem_rd = mem_q[bus.mem_addr];
    always @(posedge clk) begin
        if (bus.mem_we) mem_q[bus.mem_addr] <= bus.mem_wd;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        bus.fetch_valid = 1'b0;
        bus.fetch_pc = '0;
        bus.res_valid = 1'b0;
        bus.res_taken = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_inflight", 32'(inflight), 32'd0);
        check("rst_mispredict", 32'(bus.mispredict), 32'd0);
        check("rst_res_err", 32'(res_err), 32'd0);

        // Clear sweep: cycles 0..31.
        for (int i = 0; i < 32; i++) begin
            check("sweep_we", 32'(bus.mem_we), 32'd1);
            check("sweep_addr", 32'(bus.mem_addr), 32'(i));
            check("sweep_wd", 32'(bus.mem_wd), 32'd0);
            check("sweep_ready", 32'(bus.fetch_ready), 32'd0);
            @(negedge clk);
            #1;
        end
        check("run_ready", 32'(bus.fetch_ready), 32'd1);
        check("run_we", 32'(bus.mem_we), 32'd0);
        repeat (8) begin
            @(negedge clk);
            #1;
            check("idle_we", 32'(bus.mem_we), 32'd0);
        end

        // Lookup idx 16, then mispredict taken.
        @(negedge clk);
        bus.fetch_valid = 1'b1;
        bus.fetch_pc = 32'h40;
        #1;
        check("lk16_ready", 32'(bus.fetch_ready), 32'd1);
        check("lk16_pred", 32'(bus.pred_taken), 32'd0);
        check("lk16_addr", 32'(bus.mem_addr), 32'd16);
        @(negedge clk);
        bus.fetch_valid = 1'b0;
        bus.res_valid = 1'b1;
        bus.res_taken = 1'b1;
        #1;
        check("mp16_inflight", 32'(inflight), 32'd1);
        check("mp16_mispredict", 32'(bus.mispredict), 32'd1);
        check("mp16_we", 32'(bus.mem_we), 32'd1);
        check("mp16_addr", 32'(bus.mem_addr), 32'd16);
        check("mp16_wd", 32'(bus.mem_wd), 32'd1);
        check("mp16_ready", 32'(bus.fetch_ready), 32'd0);
        @(negedge clk);
        bus.res_valid = 1'b0;
        bus.fetch_valid = 1'b1;
        bus.fetch_pc = 32'h40;
        #1;
        check("mem16_written", 32'(mem_q[16]), 32'd1);
        check("relk_inflight", 32'(inflight), 32'd0);
        check("relk_mispredict", 32'(bus.mispredict), 32'd0);
        check("relk_pred", 32'(bus.pred_taken), 32'd1);
        check("relk_ready", 32'(bus.fetch_ready), 32'd1);
        @(negedge clk);
        bus.fetch_valid = 1'b0;
        bus.res_valid = 1'b1;
        bus.res_taken = 1'b1;
        #1;
        check("ok16_inflight", 32'(inflight), 32'd1);
        check("ok16_mispredict", 32'(bus.mispredict), 32'd0);
        check("ok16_we", 32'(bus.mem_we), 32'd0);
        @(negedge clk);
        bus.res_valid = 1'b0;
        #1;
        check("ok16_drained", 32'(inflight), 32'd0);

        // Fill the queue with idx 0..3, all predicted not-taken.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus.fetch_valid = 1'b1;
            bus.fetch_pc = 32'(k * 4);
            #1;
            check("fill_ready", 32'(bus.fetch_ready), 32'd1);
            check("fill_pred", 32'(bus.pred_taken), 32'd0);
        end
        @(negedge clk);
        bus.fetch_pc = 32'h10;
        bus.res_valid = 1'b1;
        bus.res_taken = 1'b0;
        #1;
        check("full_inflight", 32'(inflight), 32'd4);
        check("full_ready", 32'(bus.fetch_ready), 32'd0);
        check("full_mispredict", 32'(bus.mispredict), 32'd0);
        check("full_we", 32'(bus.mem_we), 32'd0);
        @(negedge clk);
        bus.fetch_valid = 1'b0;
        bus.res_valid = 1'b0;
        #1;
        check("popfull_inflight", 32'(inflight), 32'd3);

        // Oldest of three (idx 1) mispredicts; idx 2,3 are flushed unwritten.
        @(negedge clk);
        bus.res_valid = 1'b1;
        bus.res_taken = 1'b1;
        #1;
        check("flush_mispredict", 32'(bus.mispredict), 32'd1);
        check("flush_addr", 32'(bus.mem_addr), 32'd1);
        check("flush_wd", 32'(bus.mem_wd), 32'd1);
        check("flush_we", 32'(bus.mem_we), 32'd1);
        @(negedge clk);
        bus.res_valid = 1'b0;
        #1;
        check("flush_mp_clear", 32'(bus.mispredict), 32'd0);
        check("flush_inflight", 32'(inflight), 32'd0);
        check("flush_we_idle", 32'(bus.mem_we), 32'd0);
        check("mem1_written", 32'(mem_q[1]), 32'd1);
        check("mem2_untouched", 32'(mem_q[2]), 32'd0);
        check("mem3_untouched", 32'(mem_q[3]), 32'd0);

        // Resolve with an empty queue.
        @(negedge clk);
        bus.res_valid = 1'b1;
        bus.res_taken = 1'b1;
        #1;
        check("empty_mispredict", 32'(bus.mispredict), 32'd0);
        check("empty_we", 32'(bus.mem_we), 32'd0);
        check("empty_err_early", 32'(res_err), 32'd0);
        @(negedge clk);
        bus.res_valid = 1'b0;
        #1;
        check("empty_err_set", 32'(res_err), 32'd1);
        repeat (3) @(negedge clk);
        #1;
        check("empty_err_held", 32'(res_err), 32'd1);

        // Reset with two in flight.
        @(negedge clk);
        bus.fetch_valid = 1'b1;
        bus.fetch_pc = 32'h14;
        @(negedge clk);
        bus.fetch_pc = 32'h18;
        @(negedge clk);
        bus.fetch_valid = 1'b0;
        #1;
        check("pre_rst_inflight", 32'(inflight), 32'd2);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rerst_inflight", 32'(inflight), 32'd0);
        check("rerst_addr", 32'(bus.mem_addr), 32'd0);
        check("rerst_we", 32'(bus.mem_we), 32'd1);
        check("rerst_ready", 32'(bus.fetch_ready), 32'd0);
        check("rerst_err", 32'(res_err), 32'd0);
        @(negedge clk);
        #1;
        check("rerst_addr1", 32'(bus.mem_addr), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
